// File: rtl/temp_sample_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | station_pkg : shared states and constants of the temperature path  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package station_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t DRP_REQ   = 3'd1;
  localparam state_t DRP_WAIT  = 3'd2;
  localparam state_t CONV_REQ  = 3'd3;
  localparam state_t CONV_WAIT = 3'd4;
  localparam state_t WAIT_TICK = 3'd5;

  localparam logic [7:0] BLANK_BCD      = 8'hFF;
  localparam logic [6:0] XADC_TEMP_ADDR = 7'h00;

endpackage
`default_nettype wire

// File: rtl/temp_sample_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | temp_sample_sequencer_if : station enable, DRP, converter, display |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface temp_sample_sequencer_if;

  logic        CorrectStation;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic        conv_start;
  logic [11:0] conv_data;
  logic        conv_busy;
  logic        conv_done;
  logic [7:0]  conv_result;
  logic [7:0]  decimalTemp;
  logic        display;
  logic        valid;
  logic        error;

  modport master (
    input  CorrectStation, drp_drdy, drp_do, conv_busy, conv_done, conv_result,
    output drp_den, drp_daddr, conv_start, conv_data, decimalTemp, display, valid, error
  );

  modport slave (
    output CorrectStation, drp_drdy, drp_do, conv_busy, conv_done, conv_result,
    input  drp_den, drp_daddr, conv_start, conv_data, decimalTemp, display, valid, error
  );

endinterface
`default_nettype wire

// File: rtl/temp_sample_sequencer_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_tick_gen : modulo-N counter, enable, sync clear, 1-cycle tick|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sample_tick_gen #(
  parameter int unsigned N = 16
) (
  input  wire logic CLK,
  input  wire logic RST_N,
  input  wire logic i_en,
  input  wire logic i_clr,
  output logic      o_tick
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] c_last = W'(N - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && !i_clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/temp_sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | temp_sample_sequencer : periodic XADC temperature read -> BCD latch |
// | Optional 4-read averaging when TEMP_AVG_EN is defined.   Rev 1.0   |
// +--------------------------------------------------------------------+
module temp_sample_sequencer
  import station_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 10_000_000,
  parameter int unsigned TIMEOUT_CYC   = 1024,
  parameter logic [6:0]  XADC_ADDR     = XADC_TEMP_ADDR
) (
  input  wire logic               CLK,
  input  wire logic               RST_N,
  temp_sample_sequencer_if.master bus
);

  // The count "reaches" TIMEOUT_CYC on the edge where it already holds TIMEOUT_CYC-1.
  localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] c_to_max  = 16'(TIMEOUT_CYC);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_to_cnt;
  logic        r_drop;
  logic        r_conv_start;
  logic [11:0] r_conv_data;
  logic [7:0]  r_temp;
  logic        r_display;
  logic        r_valid;
  logic        r_error;
  logic        w_tick;
  logic        w_to_hit;
  logic        w_leave;
  logic        w_last_rd;
  logic        w_abort;
  logic        w_in_drp;
  logic [11:0] w_code;

`ifdef TEMP_AVG_EN
  logic [13:0] r_acc;
  logic [1:0]  r_idx;
  logic [13:0] w_acc_sum;

  assign w_acc_sum = r_acc + {2'b00, bus.drp_do[15:4]};
  assign w_code    = w_acc_sum[13:2];
  assign w_last_rd = (r_idx == 2'd3);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_next == DRP_REQ && (r_state == IDLE || r_state == WAIT_TICK)) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == DRP_WAIT && bus.drp_drdy) begin
      r_acc <= w_acc_sum;
      r_idx <= r_idx + 2'd1;
    end
  end
`else
  assign w_code    = bus.drp_do[15:4];
  assign w_last_rd = 1'b1;
`endif

  assign w_to_hit = (r_to_cnt == c_to_last);
  assign w_in_drp = (r_state == DRP_REQ) || (r_state == DRP_WAIT);
  // Losing the station mid-read is remembered so the read can finish first.
  assign w_leave  = r_drop || !bus.CorrectStation;
  assign w_abort  = (w_next == WAIT_TICK) && (r_state != WAIT_TICK) &&
                    !(r_state == CONV_WAIT && bus.conv_done);

  sample_tick_gen #(
    .N (SAMPLE_PERIOD)
  ) u_tick (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_en   (r_state != IDLE),
    .i_clr  (r_state == IDLE),
    .o_tick (w_tick)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (bus.CorrectStation) w_next = DRP_REQ;
      DRP_REQ:   w_next = DRP_WAIT;
      DRP_WAIT: begin
        if (bus.drp_drdy) begin
          if (w_leave)        w_next = IDLE;
          else if (w_last_rd) w_next = CONV_REQ;
          else                w_next = DRP_REQ;
        end else if (w_to_hit) begin
          w_next = w_leave ? IDLE : WAIT_TICK;
        end
      end
      CONV_REQ: begin
        if (!bus.CorrectStation) w_next = IDLE;
        else if (!bus.conv_busy) w_next = CONV_WAIT;
        else if (w_to_hit)       w_next = WAIT_TICK;
      end
      CONV_WAIT: begin
        if (!bus.CorrectStation)           w_next = IDLE;
        else if (bus.conv_done || w_to_hit) w_next = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!bus.CorrectStation) w_next = IDLE;
        else if (w_tick)         w_next = DRP_REQ;
      end
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_to_cnt     <= '0;
      r_drop       <= 1'b0;
      r_conv_start <= 1'b0;
      r_conv_data  <= '0;
      r_temp       <= BLANK_BCD;
      r_display    <= 1'b0;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_display    <= bus.CorrectStation;
      r_conv_start <= (r_state == CONV_REQ) && (w_next == CONV_WAIT);
      r_drop       <= w_in_drp && w_leave && (w_next == DRP_REQ || w_next == DRP_WAIT);

      if (w_next != r_state ||
          !(r_state == DRP_WAIT || r_state == CONV_REQ || r_state == CONV_WAIT)) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != c_to_max) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end

      if (r_state == DRP_WAIT && w_next == CONV_REQ) begin
        r_conv_data <= w_code;
      end

      if (w_next == IDLE && r_state != IDLE) begin
        r_temp  <= BLANK_BCD;
        r_valid <= 1'b0;
        r_error <= 1'b0;
      end else if (r_state == CONV_WAIT && w_next == WAIT_TICK && bus.conv_done) begin
        r_temp  <= bus.conv_result;
        r_valid <= 1'b1;
      end else if (w_abort) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.drp_den     = (r_state == DRP_REQ);
  assign bus.drp_daddr   = XADC_ADDR;
  assign bus.conv_start  = r_conv_start;
  assign bus.conv_data   = r_conv_data;
  assign bus.decimalTemp = r_temp;
  assign bus.display     = r_display;
  assign bus.valid       = r_valid;
  assign bus.error       = r_error;

endmodule
`default_nettype wire
